fetch_unit: RTL and testbench

- Instruction fetch sequencer that feeds the execution stage.
- Owns the fetch PC and issues in-order requests to the instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words with their PCs in a small FIFO and presents them on the execution stage's pc/inst_v/inst inputs.
- Takes branch redirects from the execution stage (pc_v_x/pc_x), flushes the FIFO and discards in-flight wrong-path responses.

---
 rtl/fetch_unit.sv | 181 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer.
// Issues in-order requests to instruction memory, buffers returned words with
// their PCs and feeds them to the execution stage. Branch redirects flush the
// buffer and drop responses still owed to the wrong path.
//
// state | meaning
// BOOT  | single idle cycle after reset, no request
// RUN   | normal fetch, responses are pushed into the buffer
// DRAIN | wrong-path responses still owed; each one is dropped
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_v_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic [31:0] pc_o,
    output logic        inst_v_o,
    output logic [31:0] inst_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [31:0] BOOT_PC = {RESET_PC[31:2], 2'b00};

    logic [1:0]    r_state;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_discard;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [31:0]   r_fifo_pc   [FIFO_DEPTH];
    logic [31:0]   r_fifo_inst [FIFO_DEPTH];
    logic [31:0]   r_last_pc;
    logic [31:0]   r_last_inst;

    logic          w_redirect;
    logic          w_run;
    logic          w_req;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_nonempty;
    logic [CW-1:0] w_level;
    logic [CW-1:0] w_discard_nxt;
    logic [31:0]   w_target;
    logic          w_unused_bits;

    assign w_target      = {redirect_pc_i[31:2], 2'b00};
    assign w_unused_bits = ^redirect_pc_i[1:0];
    assign w_nonempty    = (r_count != '0);
    // The execution stage cannot be valid during BOOT, so a redirect there is noise.
    assign w_redirect    = redirect_v_i && (r_state != ST_BOOT);
    assign w_run         = (r_state == ST_RUN);
    assign w_level       = r_out + r_count;
    assign w_req         = w_run && (w_level < CW'(FIFO_DEPTH)) && !redirect_v_i;
    assign w_accept      = w_req && imem_gnt_i;
    assign w_push        = w_run && imem_rvalid_i && !w_redirect;
    assign w_pop         = w_nonempty && !stall_i && !redirect_v_i;

    assign imem_req_o  = w_req;
    assign imem_addr_o = r_fetch_pc;
    assign inst_v_o    = w_pop;
    assign pc_o        = w_nonempty ? r_fifo_pc[r_rd_ptr]   : r_last_pc;
    assign inst_o      = w_nonempty ? r_fifo_inst[r_rd_ptr] : r_last_inst;

    // Responses still owed after this cycle; a response arriving now is dropped.
    always_comb begin
        w_discard_nxt = r_out - CW'(imem_rvalid_i);
        if (r_state == ST_DRAIN) begin
            w_discard_nxt = r_discard - CW'(imem_rvalid_i);
        end
    end

    // Sequencer state and wrong-path discard count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_BOOT;
            r_discard <= '0;
        end else begin
            case (r_state)
                ST_BOOT: r_state <= ST_RUN;
                ST_RUN: begin
                    if (w_redirect) begin
                        r_discard <= w_discard_nxt;
                        r_state   <= (w_discard_nxt != '0) ? ST_DRAIN : ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    r_discard <= w_discard_nxt;
                    if (w_discard_nxt == '0) begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_BOOT;
            endcase
        end
    end

    // Requests granted but not yet answered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out <= '0;
        end else begin
            r_out <= r_out + CW'(w_accept) - CW'(imem_rvalid_i);
        end
    end

    // Fetch PC and response-tag PC; both jump to the target on a redirect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= BOOT_PC;
            r_rsp_pc   <= BOOT_PC;
        end else if (w_redirect) begin
            r_fetch_pc <= w_target;
            r_rsp_pc   <= w_target;
        end else begin
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_push) begin
                r_rsp_pc <= r_rsp_pc + 32'd4;
            end
        end
    end

    // Buffer pointers and occupancy; a redirect empties the buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Buffer storage; entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_rsp_pc;
            r_fifo_inst[r_wr_ptr] <= imem_rdata_i;
        end
    end

    // Remember the last head shown so pc_o/inst_o hold while the buffer is empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_pc   <= '0;
            r_last_inst <= '0;
        end else if (w_nonempty) begin
            r_last_pc   <= r_fifo_pc[r_rd_ptr];
            r_last_inst <= r_fifo_inst[r_rd_ptr];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model plus a queue-based reference of
// the fetch/issue rules, compared every cycle, with literal spot checks.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        redirect_v_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        stall_i = 1'b0;
    logic [31:0] pc_o;
    logic        inst_v_o;
    logic [31:0] inst_o;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_v_i  (redirect_v_i),
        .redirect_pc_i (redirect_pc_i),
        .stall_i       (stall_i),
        .pc_o          (pc_o),
        .inst_v_o      (inst_v_o),
        .inst_o        (inst_o)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // reference model
    bit          m_boot;
    int          m_out;
    int          m_discard;
    logic [31:0] m_fetch;
    logic [31:0] m_rsp;
    logic [31:0] m_last_pc;
    logic [31:0] m_last_inst;
    logic [31:0] m_buf[$];

    // memory model
    logic [31:0] mem_q[$];
    bit          rsp_en;

    // per-phase logs
    logic [31:0] iss_pc[$];
    logic [31:0] iss_cyc[$];
    logic [31:0] req_addr[$];
    logic [31:0] req_cyc[$];
    logic [31:0] all_req[$];
    logic [31:0] all_v[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic lit(input string name, input logic [31:0] q[$], input int idx,
                       input logic [31:0] exp);
        if (idx >= q.size()) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got no entry %0d expected %h", name, idx, exp);
        end else begin
            chk(name, q[idx], exp);
        end
    endtask

    task automatic clear_logs();
        iss_pc.delete();
        iss_cyc.delete();
        req_addr.delete();
        req_cyc.delete();
        all_req.delete();
        all_v.delete();
    endtask

    task automatic model_reset();
        m_boot      = 1'b1;
        m_out       = 0;
        m_discard   = 0;
        m_fetch     = 32'h0;
        m_rsp       = 32'h0;
        m_last_pc   = 32'h0;
        m_last_inst = 32'h0;
        m_buf.delete();
        mem_q.delete();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
    endtask

    // Holds reset for two cycles then releases it on a falling edge; cycle 0 follows.
    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        imem_gnt_i   = 1'b0;
        redirect_v_i = 1'b0;
        stall_i      = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cyc   = 0;
        clear_logs();
    endtask

    // One cycle: drive memory, compare against model, advance model at the edge.
    task automatic step();
        logic        e_req, e_v, rv, gnt, red, dreq, acc;
        logic [31:0] e_addr, e_pc, e_inst, tgt, daddr;
        if (rsp_en && mem_q.size() > 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(mem_q[0]);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
        end
        #1;
        e_req  = !m_boot && (m_discard == 0) && (m_out + m_buf.size() < 4) && !redirect_v_i;
        e_addr = {m_fetch[31:2], 2'b00};
        e_v    = (m_buf.size() > 0) && !stall_i && !redirect_v_i;
        e_pc   = (m_buf.size() > 0) ? m_buf[0] : m_last_pc;
        e_inst = (m_buf.size() > 0) ? mem_word(m_buf[0]) : m_last_inst;
        chk("imem_req", 32'(imem_req_o), 32'(e_req));
        if (e_req) chk("imem_addr", imem_addr_o, e_addr);
        chk("inst_v", 32'(inst_v_o), 32'(e_v));
        chk("pc", pc_o, e_pc);
        chk("inst", inst_o, e_inst);
        all_req.push_back(32'(imem_req_o));
        all_v.push_back(32'(inst_v_o));
        if (imem_req_o && imem_gnt_i) begin
            req_addr.push_back(imem_addr_o);
            req_cyc.push_back(32'(cyc));
        end
        if (inst_v_o) begin
            iss_pc.push_back(pc_o);
            iss_cyc.push_back(32'(cyc));
        end
        rv    = imem_rvalid_i;
        gnt   = imem_gnt_i;
        red   = redirect_v_i;
        tgt   = redirect_pc_i;
        dreq  = imem_req_o;
        daddr = imem_addr_o;
        @(posedge clk);
        if (rv) void'(mem_q.pop_front());
        if (dreq && gnt) mem_q.push_back(daddr);
        if (m_boot) begin
            m_boot = 1'b0;
        end else begin
            acc = e_req && gnt;
            if (m_buf.size() > 0) begin
                m_last_pc   = m_buf[0];
                m_last_inst = mem_word(m_buf[0]);
            end
            if (red) begin
                if (m_discard > 0) m_discard = m_discard - int'(rv);
                else               m_discard = m_out - int'(rv);
                m_out   = m_out - int'(rv);
                m_buf.delete();
                m_fetch = {tgt[31:2], 2'b00};
                m_rsp   = m_fetch;
            end else if (m_discard > 0) begin
                if (rv) begin
                    m_discard--;
                    m_out--;
                end
            end else begin
                if (e_v) void'(m_buf.pop_front());
                if (rv) begin
                    m_buf.push_back(m_rsp);
                    m_rsp = m_rsp + 32'd4;
                    m_out--;
                end
                if (acc) begin
                    m_fetch = m_fetch + 32'd4;
                    m_out++;
                end
                if (m_out + m_buf.size() > 4) begin
                    n_bad++;
                    $display("FAIL occupancy: got %0d expected at most 4", m_out + m_buf.size());
                end
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    logic [31:0] last_a;
    logic [31:0] mark;
    bit          seq_ok;

    initial begin
        rsp_en = 1'b1;
        model_reset();

        // zero-wait memory from reset
        do_reset();
        imem_gnt_i = 1'b1;
        repeat (12) step();
        lit("first_req_cycle", req_cyc, 0, 32'd1);
        lit("first_req_addr", req_addr, 0, 32'h0);
        lit("first_issue_cycle", iss_cyc, 0, 32'd3);
        lit("issue0_pc", iss_pc, 0, 32'h0);
        lit("issue1_pc", iss_pc, 1, 32'h4);
        lit("issue1_cycle", iss_cyc, 1, 32'd4);
        lit("issue2_pc", iss_pc, 2, 32'h8);
        last_a = (iss_pc.size() > 0) ? iss_pc[iss_pc.size()-1] : 32'h0;

        // stall with streaming memory: buffer fills, requests stop
        clear_logs();
        stall_i = 1'b1;
        repeat (6) step();
        lit("stall_req_dropped", all_req, 5, 32'd0);
        lit("stall_no_issue", all_v, 5, 32'd0);
        stall_i = 1'b0;
        mark = 32'(cyc);
        clear_logs();
        repeat (8) step();
        lit("resume_cycle", iss_cyc, 0, mark);
        lit("resume_pc", iss_pc, 0, last_a + 32'd4);
        seq_ok = (iss_pc.size() >= 8);
        for (int i = 1; i < iss_pc.size(); i++) begin
            if (iss_pc[i] != iss_pc[i-1] + 32'd4) seq_ok = 1'b0;
        end
        chk("resume_in_order", 32'(seq_ok), 32'd1);

        // redirect with two responses in flight
        imem_gnt_i = 1'b0;
        repeat (4) step();
        rsp_en     = 1'b0;
        imem_gnt_i = 1'b1;
        repeat (2) step();
        imem_gnt_i    = 1'b0;
        redirect_v_i  = 1'b1;
        redirect_pc_i = 32'h0000_0100;
        mark = 32'(cyc);
        step();
        redirect_v_i = 1'b0;
        rsp_en       = 1'b1;
        imem_gnt_i   = 1'b1;
        clear_logs();
        repeat (12) step();
        lit("drain_no_req", all_req, 0, 32'd0);
        lit("drain_no_req2", all_req, 1, 32'd0);
        lit("target_req_addr", req_addr, 0, 32'h100);
        lit("target_req_cycle", req_cyc, 0, mark + 32'd3);
        lit("target_first_issue", iss_pc, 0, 32'h100);

        // redirect colliding with rvalid and a valid head
        redirect_v_i  = 1'b1;
        redirect_pc_i = 32'h0000_0203;
        clear_logs();
        step();
        lit("redirect_suppress", all_v, 0, 32'd0);
        redirect_v_i = 1'b0;
        clear_logs();
        repeat (6) step();
        lit("aligned_req_addr", req_addr, 0, 32'h200);
        lit("aligned_req_now", all_req, 0, 32'd1);
        lit("aligned_first_issue", iss_pc, 0, 32'h200);

        // asynchronous reset between edges
        repeat (3) step();
        #2;
        reset = 1'b0;
        #1;
        chk("async_req", 32'(imem_req_o), 32'd0);
        chk("async_inst_v", 32'(inst_v_o), 32'd0);
        chk("async_pc", pc_o, 32'h0);
        chk("async_inst", inst_o, 32'h0);
        @(negedge clk);

        // restart with grant held low for three request cycles
        do_reset();
        imem_gnt_i = 1'b0;
        repeat (4) step();
        lit("boot_no_req", all_req, 0, 32'd0);
        lit("gnt_low_req", all_req, 3, 32'd1);
        chk("gnt_low_addr", imem_addr_o, 32'h0);
        imem_gnt_i = 1'b1;
        repeat (6) step();
        lit("gnt_first_addr", req_addr, 0, 32'h0);
        lit("gnt_first_cycle", req_cyc, 0, 32'd4);
        lit("gnt_next_addr", req_addr, 1, 32'h4);
        lit("restart_issue_pc", iss_pc, 0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
